// File: rtl/nco_search_pkg.sv
// Shared types and constants for the NCO Doppler/phase search scheduler.
package nco_search_pkg;

  localparam int unsigned BIN_W = 8;

  typedef logic [1:0] phase_t;

  localparam phase_t LAST_PHASE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SYNC,
    ST_DWELL,
    ST_WAIT_E,
    ST_NEXT,
    ST_FIN
  } state_t;

endpackage

// File: rtl/nco_search_ctrl_if.sv
// NCO / correlator bus of the search scheduler.
// master: the scheduler (drives tuning word, sync, phase; receives ticks and energies).
// slave : the NCO + correlator side.
interface nco_search_ctrl_if
  import nco_search_pkg::*;
#(
  parameter int unsigned STEP_W = 24,
  parameter int unsigned EW     = 16
);
  logic [STEP_W-1:0] nco_step;
  logic              nco_sync;
  phase_t            nco_phase;
  logic              nco_tick;
  logic [EW-1:0]     energy_in;
  logic              energy_valid;

  modport master (
    output nco_step, nco_sync, nco_phase,
    input  nco_tick, energy_in, energy_valid
  );

  modport slave (
    input  nco_step, nco_sync, nco_phase,
    output nco_tick, energy_in, energy_valid
  );
endinterface

// File: rtl/nco_search_ctrl_dwell_timer.sv
// Dwell timer: counts qualified NCO ticks after a clear and flags the
// DWELL-th tick combinationally so the FSM leaves on that same edge.
module dwell_timer #(
  parameter int unsigned DWELL = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expire
);
  localparam int unsigned CW = $clog2(DWELL + 1);

  logic [CW-1:0] cnt;

  // Tick counter; clear dominates so a tick coincident with clear is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Expire on the tick that completes the dwell
  always_comb begin
    expire = tick && (cnt == CW'(DWELL - 1));
  end
endmodule

// File: rtl/nco_search_ctrl.sv
// NCO Doppler/phase search scheduler.
// Steps the NCO tuning word through N_BINS bins (and all 4 VCO phases when
// NCO_SEARCH_PHASE_EN is defined), syncs the VCO, dwells DWELL NCO ticks per
// hypothesis, then tracks the strongest correlator energy and raises lock.
module nco_search_ctrl
  import nco_search_pkg::*;
#(
  parameter int unsigned STEP_W    = 24,
  parameter int unsigned STEP_BASE = 10400,
  parameter int unsigned STEP_INC  = 1,
  parameter int unsigned N_BINS    = 16,
  parameter int unsigned DWELL     = 1023,
  parameter int unsigned EW        = 16,
  parameter int unsigned THRESH    = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  nco_search_ctrl_if.master nco,
  output logic              busy,
  output logic              done,
  output logic [BIN_W-1:0]  best_bin,
  output phase_t            best_phase,
  output logic [EW-1:0]     best_energy,
  output logic              lock
);

  state_t            state, state_nx;
  logic [BIN_W-1:0]  bin;
  phase_t            phase;
  logic              expire;
  logic              last_hyp;
  logic              first_hyp;
  logic              dwell_clear;
  logic              dwell_tick;

  // Dwell timer is cleared in SYNC and only sees ticks while dwelling
  always_comb begin
    dwell_clear = (state == ST_SYNC);
    dwell_tick  = nco.nco_tick && (state == ST_DWELL);
  end

  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (dwell_clear),
    .tick   (dwell_tick),
    .expire (expire)
  );

  // Hypothesis position flags
  always_comb begin
`ifdef NCO_SEARCH_PHASE_EN
    last_hyp  = (bin == BIN_W'(N_BINS - 1)) && (phase == LAST_PHASE);
`else
    last_hyp  = (bin == BIN_W'(N_BINS - 1));
`endif
    first_hyp = (bin == '0) && (phase == '0);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; abort overrides everything, including start in IDLE
  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start) state_nx = ST_LOAD;
        ST_LOAD:   state_nx = ST_SYNC;
        ST_SYNC:   state_nx = ST_DWELL;
        ST_DWELL:  if (expire) state_nx = ST_WAIT_E;
        ST_WAIT_E: if (nco.energy_valid) state_nx = ST_NEXT;
        ST_NEXT:   state_nx = last_hyp ? ST_FIN : ST_LOAD;
        ST_FIN:    state_nx = ST_IDLE;
        default:   state_nx = ST_IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    busy         = (state != ST_IDLE);
    done         = (state == ST_FIN);
    nco.nco_sync = (state == ST_SYNC);
  end

  // Hypothesis counters, NCO programming, max tracker and lock flag.
  // Everything is frozen on abort so results and the NCO word stay as they were.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin           <= '0;
      phase         <= '0;
      nco.nco_step  <= STEP_W'(STEP_BASE);
      nco.nco_phase <= '0;
      best_bin      <= '0;
      best_phase    <= '0;
      best_energy   <= '0;
      lock          <= 1'b0;
    end else if (!abort) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            bin         <= '0;
            phase       <= '0;
            best_bin    <= '0;
            best_phase  <= '0;
            best_energy <= '0;
            lock        <= 1'b0;
          end
        end
        ST_LOAD: begin
          nco.nco_step  <= STEP_W'(STEP_BASE) + STEP_W'(bin) * STEP_W'(STEP_INC);
          nco.nco_phase <= phase;
        end
        ST_WAIT_E: begin
          if (nco.energy_valid && (first_hyp || (nco.energy_in > best_energy))) begin
            best_energy <= nco.energy_in;
            best_bin    <= bin;
            best_phase  <= phase;
          end
        end
        ST_NEXT: begin
          if (!last_hyp) begin
`ifdef NCO_SEARCH_PHASE_EN
            if (phase == LAST_PHASE) begin
              phase <= '0;
              bin   <= bin + BIN_W'(1);
            end else begin
              phase <= phase + 2'd1;
            end
`else
            bin <= bin + BIN_W'(1);
`endif
          end
        end
        ST_FIN: begin
          lock <= (best_energy > EW'(THRESH));
        end
        default: ;
      endcase
    end
  end

endmodule
